sva_result_collector: RTL

- Downstream stage of the per-property SVA FSM checker. It consumes that checker's per-evaluation verdict strobes (succ / fail / lazy_succ) on sys_clk.
- Events are bucketed into "frames", where a frame is the interval between consecutive gclk_posedge_flag pulses.
- One summary record per non-empty frame is pushed through a small FIFO to a valid/ready consumer, such as a log writer or host interface.
- Saturating run totals and first-fail capture are maintained for the testbench and for status registers.

---
 rtl/sva_collect_pkg.sv | 28 ++
 rtl/sva_collect_fifo.sv | 62 ++++++
 rtl/sva_result_collector.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sva_collect_pkg.sv
// Shared types for the SVA result collector: controller states, the
// per-frame summary record and a saturating increment helper.
package sva_collect_pkg;

  localparam int SVA_FRAME_W = 16;
  localparam int SVA_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } sva_state_t;

  // One record per non-empty frame, frame index in the most significant bits.
  typedef struct packed {
    logic [SVA_FRAME_W-1:0] frame_idx;
    logic [SVA_CNT_W-1:0]   succ_n;
    logic [SVA_CNT_W-1:0]   fail_n;
    logic [SVA_CNT_W-1:0]   lazy_n;
  } sva_rec_t;

  // Counters up to 32 bits wide share this helper; the value sticks at max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sva_collect_fifo.sv
// Single-clock record FIFO for the SVA result collector. DEPTH must be a
// power of two; a push is accepted while full when a pop happens in the
// same cycle. The head reads as zero while empty.
module sva_collect_fifo
  import sva_collect_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = sva_rec_t
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty gate on the head hides stale contents.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Present the head, forced to zero when nothing is stored.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

endmodule

// File: rtl/sva_result_collector.sv
// Collects per-evaluation SVA verdict strobes into frames delimited by
// frame_tick, queues one summary record per non-empty frame and keeps
// saturating run totals plus first-fail capture.
// Optional: define SVA_COLLECT_HALT_ON_FAIL_EN to stop collection at the
// first fail (HALT state) after pushing the partial frame that holds it.
module sva_result_collector
  import sva_collect_pkg::*;
#(
  parameter int FRAME_W    = SVA_FRAME_W,
  parameter int CNT_W      = SVA_CNT_W,
  parameter int TOT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic                     evt_vld,
  input  logic                     evt_succ,
  input  logic                     evt_fail,
  input  logic                     evt_lazy,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [FRAME_W+3*CNT_W-1:0] rec_data,
  output logic [TOT_W-1:0]         tot_succ,
  output logic [TOT_W-1:0]         tot_fail,
  output logic [TOT_W-1:0]         tot_lazy,
  output logic                     first_fail_vld,
  output logic [FRAME_W-1:0]       first_fail_frame,
  output logic                     overflow,
  output logic                     busy
);

  // Saturation limits; the record fields and totals must stay within 32 bits.
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] TOT_MAX = 32'((64'd1 << TOT_W) - 64'd1);

  sva_state_t          state;
  sva_state_t          next_state;
  logic [FRAME_W-1:0]  frame_idx;
  logic [CNT_W-1:0]    succ_n;
  logic [CNT_W-1:0]    fail_n;
  logic [CNT_W-1:0]    lazy_n;
  logic [FRAME_W-1:0]  nxt_idx;
  logic [CNT_W-1:0]    nxt_succ;
  logic [CNT_W-1:0]    nxt_fail;
  logic [CNT_W-1:0]    nxt_lazy;
  logic                inc_succ;
  logic                inc_fail;
  logic                inc_lazy;
  logic                frame_nonempty;
  logic                start_run;
  logic                close_push;
  logic                halt_push;
  logic                push;
  sva_rec_t            push_rec;
  sva_rec_t            head_rec;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                fifo_drop;

  assign inc_succ       = evt_vld && evt_succ;
  assign inc_fail       = evt_vld && evt_fail;
  assign inc_lazy       = evt_vld && evt_lazy;
  assign frame_nonempty = |{succ_n, fail_n, lazy_n};
  assign busy           = (state != IDLE);
  assign rec_valid      = !fifo_empty;
  assign rec_data       = head_rec;
  assign pop            = rec_valid && rec_ready;
  assign push           = close_push || halt_push;
  assign fifo_drop      = push && fifo_full && !pop;

  // Controller state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  // Next state plus the run-start and record-push strobes.
  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    close_push = 1'b0;
    halt_push  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          next_state = RUN;
          start_run  = 1'b1;
        end
      end
      RUN: begin
        if (frame_tick && frame_nonempty) close_push = 1'b1;
        if (!enable) next_state = DRAIN;
`ifdef SVA_COLLECT_HALT_ON_FAIL_EN
        // The fail record wins the single push slot over a coincident close.
        if (inc_fail && !first_fail_vld) begin
          close_push = 1'b0;
          halt_push  = 1'b1;
          next_state = HALT;
        end
`endif
      end
      DRAIN: begin
        close_push = frame_nonempty;
        next_state = IDLE;
      end
`ifdef SVA_COLLECT_HALT_ON_FAIL_EN
      HALT: begin
        if (!enable) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Frame counters after this cycle; a same-cycle event belongs to the new frame.
  always_comb begin
    nxt_idx  = frame_idx;
    nxt_succ = succ_n;
    nxt_fail = fail_n;
    nxt_lazy = lazy_n;
    if (frame_tick) begin
      nxt_idx  = frame_idx + FRAME_W'(1);
      nxt_succ = CNT_W'(inc_succ);
      nxt_fail = CNT_W'(inc_fail);
      nxt_lazy = CNT_W'(inc_lazy);
    end else begin
      if (inc_succ) nxt_succ = CNT_W'(sat_inc(32'(succ_n), CNT_MAX));
      if (inc_fail) nxt_fail = CNT_W'(sat_inc(32'(fail_n), CNT_MAX));
      if (inc_lazy) nxt_lazy = CNT_W'(sat_inc(32'(lazy_n), CNT_MAX));
    end
  end

  // Record to push: the closing frame, or the partial frame holding the first fail.
  always_comb begin
    push_rec = '0;
    if (halt_push) begin
      push_rec.frame_idx = nxt_idx;
      push_rec.succ_n    = nxt_succ;
      push_rec.fail_n    = nxt_fail;
      push_rec.lazy_n    = nxt_lazy;
    end else begin
      push_rec.frame_idx = frame_idx;
      push_rec.succ_n    = succ_n;
      push_rec.fail_n    = fail_n;
      push_rec.lazy_n    = lazy_n;
    end
  end

  // Frame counters, run totals and sticky status; cleared on each run start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frame_idx        <= '0;
      succ_n           <= '0;
      fail_n           <= '0;
      lazy_n           <= '0;
      tot_succ         <= '0;
      tot_fail         <= '0;
      tot_lazy         <= '0;
      first_fail_vld   <= 1'b0;
      first_fail_frame <= '0;
      overflow         <= 1'b0;
    end else begin
      if (start_run) begin
        frame_idx        <= '0;
        succ_n           <= '0;
        fail_n           <= '0;
        lazy_n           <= '0;
        tot_succ         <= '0;
        tot_fail         <= '0;
        tot_lazy         <= '0;
        first_fail_vld   <= 1'b0;
        first_fail_frame <= '0;
        overflow         <= 1'b0;
      end else if (state == RUN) begin
        frame_idx <= nxt_idx;
        succ_n    <= nxt_succ;
        fail_n    <= nxt_fail;
        lazy_n    <= nxt_lazy;
        if (inc_succ) tot_succ <= TOT_W'(sat_inc(32'(tot_succ), TOT_MAX));
        if (inc_fail) tot_fail <= TOT_W'(sat_inc(32'(tot_fail), TOT_MAX));
        if (inc_lazy) tot_lazy <= TOT_W'(sat_inc(32'(tot_lazy), TOT_MAX));
        if (inc_fail && !first_fail_vld) begin
          first_fail_vld   <= 1'b1;
          first_fail_frame <= nxt_idx;
        end
      end
      if (fifo_drop) overflow <= 1'b1;
    end
  end

  sva_collect_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (sva_rec_t)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
